// File: rtl/mc_pkg.sv
// mc_pkg: shared state, opcode and control-field encodings for mc_control.
// Ports: none (package).
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADDR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC,
        S_EXECI,
        S_RWB,
        S_BRANCH,
        S_HALT
    } mc_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_OFF  = 2'b11;

endpackage

// File: rtl/mc_instret.sv
// mc_instret: 32-bit retired-instruction counter, wraps modulo 2^32.
// Ports: clk, rst_n (async active-low), inc (one retirement this cycle), count (retired total).
module mc_instret (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (inc)
            count <= count + 32'd1;

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle main control FSM (fetch/decode/execute/memory/write-back).
// Ports: clk, rst_n (async active-low), opcode[6:0], mem_ready in; datapath strobes and
// selects (PCWrite..PCSource, ALUSrcB[1:0], ALUop[1:0]), halted, instret[31:0] out.
// Macro MC_CONTROL_INSTRET_EN: when defined instret counts retirements, else it is tied to 0.
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  opcode,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        PCWriteCond,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        MemtoReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic        PCSource,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUop,
    output logic        halted,
    output logic [31:0] instret
);

    mc_state_t state, nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= S_FETCH;
        else
            state <= nxt;

    always_comb begin
        nxt         = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        PCSource    = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUop       = ALUOP_ADD;
        halted      = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = SRCB_OFF;
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADDR;
                    OP_RTYPE:          nxt = S_EXEC;
                    OP_IALU:           nxt = S_EXECI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    default:           nxt = S_HALT;
                endcase
            end
            S_MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                nxt     = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                nxt      = S_FETCH;
            end
            S_MEMWRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALUOP_FUNCT;
                nxt     = S_RWB;
            end
            S_EXECI: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUop   = ALUOP_IMM;
                nxt     = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                nxt      = S_FETCH;
            end
            S_BRANCH: begin
                PCWriteCond = 1'b1;
                ALUSrcA     = 1'b1;
                ALUop       = ALUOP_SUB;
                PCSource    = 1'b1;
                nxt         = S_FETCH;
            end
            S_HALT: halted = 1'b1;
            default: nxt = S_FETCH;
        endcase
    end

`ifdef MC_CONTROL_INSTRET_EN
    // An instruction retires on the edge that takes the FSM back into FETCH.
    logic retire;
    assign retire = (state == S_MEMWB) || (state == S_RWB) || (state == S_BRANCH) ||
                    ((state == S_MEMWRITE) && mem_ready);

    mc_instret u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (retire),
        .count (instret)
    );
`else
    assign instret = '0;
`endif

endmodule
